// File: rtl/charge_pkg.sv
// Shared key definitions for the charging-station controller: key indices,
// default channel count and the key-code type consumed by the control FSM.
package charge_pkg;

  localparam int NUM_KEYS = 4;
  localparam int CODE_W   = 2;

  localparam int KEY_SIGNAL = 0;
  localparam int KEY_ONE    = 1;
  localparam int KEY_TEN    = 2;
  localparam int KEY_CANCEL = 3;

  typedef logic [CODE_W-1:0] key_code_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce counter, stable level and
// registered press/release pulses. KEY_AUTOREPEAT_EN adds a hold counter.
module key_debounce_ch #(
  parameter int DB_CYCLES     = 1000000
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter bit RPT_EN        = 1'b0,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 20000000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          lvl_d1_q, lvl_d1_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          sync2;

  assign sync2 = sync_q[1];

`ifdef KEY_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          rep_fire;

  // Reload lands the next fire exactly REPEAT_PERIOD cycles later (needs PERIOD <= DELAY).
  always_comb begin
    hold_d   = '0;
    rep_fire = 1'b0;
    if (RPT_EN && level_q) begin
      if (hold_q == HW'(REPEAT_DELAY)) begin
        rep_fire = 1'b1;
        hold_d   = HW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`endif

  always_comb begin
    sync_d   = {sync_q[0], key_raw};
    cnt_d    = '0;
    level_d  = level_q;
    lvl_d1_d = level_q;
    if (sync2 != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) level_d = sync2;
      else                             cnt_d   = cnt_q + 1'b1;
    end
    press_d = level_q & ~lvl_d1_q;
    rel_d   = ~level_q & lvl_d1_q;
`ifdef KEY_AUTOREPEAT_EN
    press_d = press_d | rep_fire;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      lvl_d1_q <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      lvl_d1_q <= lvl_d1_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;

endmodule

// File: rtl/key_event_gen.sv
// Front-panel key conditioner: per-key debounced level/press/release plus a
// serialized press-event stream. Optional auto-repeat under KEY_AUTOREPEAT_EN.
module key_event_gen #(
  parameter int                         NUM_KEYS      = charge_pkg::NUM_KEYS,
  parameter int                         DB_CYCLES     = 1000000,
  parameter int                         CODE_W        = charge_pkg::CODE_W,
  parameter int                         REPEAT_DELAY  = 50000000,
  parameter int                         REPEAT_PERIOD = 20000000,
  parameter logic [NUM_KEYS-1:0]        REPEAT_MASK   = 4'b0110
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                evt_valid,
  output logic [CODE_W-1:0]   evt_code
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES     (DB_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .RPT_EN        (REPEAT_MASK[i]),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .key_raw (key_raw[i]),
      .level   (key_level[i]),
      .press   (key_press[i]),
      .rel     (key_release[i])
    );
  end

  logic [NUM_KEYS-1:0] pending_q, pending_d, pend_all;
  logic                evt_valid_q, evt_valid_d;
  logic [CODE_W-1:0]   evt_code_q, evt_code_d;

  // This cycle's presses are merged in directly so an event leaves one cycle after its pulse.
  always_comb begin
    pend_all    = pending_q | key_press;
    pending_d   = pend_all;
    evt_valid_d = 1'b0;
    evt_code_d  = evt_code_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (pend_all[i] && !evt_valid_d) begin
        evt_valid_d  = 1'b1;
        evt_code_d   = CODE_W'(i);
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
    end else begin
      pending_q   <= pending_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Input-side conditioner for the charging-station controller. It turns raw, bouncy front-panel buttons (card signal, 1-yuan, 10-yuan, cancel) into clean single-cycle press/release pulses plus a serialized key-event stream.
- Sits between board pins and the control FSM, which consumes only synchronous, debounced one-cycle events and never raw edges.

Parameters:
- NUM_KEYS, 4, number of button channels (index constants in package).
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); minimum 2.
- CODE_W, 2, width of evt_code; must satisfy 2**CODE_W >= NUM_KEYS.
- REPEAT_DELAY, 50000000, hold cycles before first auto-repeat (KEY_AUTOREPEAT_EN only).
- REPEAT_PERIOD, 20000000, cycles between subsequent repeats (KEY_AUTOREPEAT_EN only).
- REPEAT_MASK, 4'b0110, channels eligible for auto-repeat (KEY_AUTOREPEAT_EN only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_raw  in  NUM_KEYS  raw button levels, active-high (1 = pressed), asynchronous to clk.
- key_level  out  NUM_KEYS  debounced level per key.
- key_press  out  NUM_KEYS  one-cycle pulse per key on accepted 0->1.
- key_release  out  NUM_KEYS  one-cycle pulse per key on accepted 1->0.
- evt_valid  out  1  one-cycle strobe, one event per cycle maximum.
- evt_code  out  CODE_W  key index of the current event; holds last value when evt_valid=0.

Behaviour:
- Reset (reset=0, async): synchronizers, counters, key_level, key_press, key_release, pending, evt_valid and evt_code are all 0.
- Per channel, input stage: 2-flop synchronizer producing sync2.
- Per channel, debounce counter:
  - Clears whenever sync2 == key_level.
  - Increments while sync2 != key_level.
  - When the counter equals DB_CYCLES-1 and sync2 still differs: key_level <= sync2 and the counter clears.
  - A bounce (sync2 returns to key_level) before that point clears the counter; no change is accepted.
- Pulses: key_press/key_release are registered, high for exactly the one cycle after key_level changes.
- Latency: a raw level held stable from edge k gives key_press high during cycle k+DB_CYCLES+3.
- Event serializer:
  - A pending[NUM_KEYS] register ORs in key_press each cycle.
  - Each cycle, if pending != 0: evt_valid <= 1, evt_code <= lowest set index, and that bit clears.
  - Simultaneous presses are emitted one per cycle in ascending index order.
  - A press arriving for a key whose pending bit is still set coalesces into that one event.
  - Releases are not sent to the event stream.
- Counter width is clog2(DB_CYCLES). No wrap-around is possible, because the counter saturates/clears at DB_CYCLES-1.
- Reset mid-press: everything returns to 0. If key_raw is still high after reset releases, a fresh press is accepted after the full latency; there is no suppression.
- No state machine beyond the per-channel two-state stable level (RELEASED/PRESSED = key_level).

Optional Feature:
- KEY_AUTOREPEAT_EN defined:
  - Each REPEAT_MASK channel gets a hold counter that starts when key_level rises.
  - A repeat key_press pulse (and pending set) fires after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles while key_level stays 1.
  - Release or reset clears the hold counter.
- KEY_AUTOREPEAT_EN undefined: no hold counters; exactly one key_press per accepted press; REPEAT_* parameters are ignored.

Decomposition:
- Package charge_pkg:
  - Key index constants KEY_SIGNAL=0, KEY_ONE=1, KEY_TEN=2, KEY_CANCEL=3.
  - NUM_KEYS default and CODE_W.
  - The shared key-code type used by the control FSM.
- Sub-module key_debounce_ch: one channel holding the synchronizer, debounce counter, level and press/release pulse generation (plus the hold counter under the macro). It is instantiated NUM_KEYS times via generate.
- Serializer stays in the top.

Test Plan:
All tests use DB_CYCLES=4.
- Reset release with key_raw=0 -> all outputs 0 for 20 cycles; no evt_valid.
- Clean press of key 1 at edge 10, held -> key_level[1]=1 from cycle 16, key_press[1]=1 only at cycle 17, evt_valid=1 with evt_code=1 at cycle 18. Release -> one key_release[1] pulse after 7 cycles, no event.
- Bounce: key 2 toggles 1,0,1,0 each 2 cycles, then stays 0 -> key_level stays 0; no key_press, no evt_valid.
- Keys 3 and 0 pressed on the same edge -> both key_press pulse in the same cycle; evt_valid on two consecutive cycles with evt_code=0 then 3.
- Reset asserted mid-count with key 0 held through release -> outputs 0 immediately; key_press[0] 7 cycles after reset deasserts.
- With KEY_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5, holding key 2 -> key_press[2] at the initial edge, +10, +15, +20. Key 0 (not in mask) gives a single pulse.
